sram_banked_ctrl: RTL and testbench

SRAM_BANKED_CTRL -- requirements
Module: sram_banked_ctrl

---
 rtl/sram_banked_ctrl.sv | 150 +++++++++++++++
 tb/tb_sram_banked_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sram_banked_ctrl.sv
// rtl/sram_banked_ctrl.sv - banked SRAM controller over gf180mcu_sram_wrapper macros
// Zero-clears all rows after reset, then grants one access per cycle with 1-cycle read latency.

module gf180mcu_sram_wrapper #(
  parameter int WORDS = 64,
  parameter int WIDTH = 32,
  localparam int AWID = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             cen,
  input  logic             gwen,
  input  logic [WIDTH-1:0] wen,
  input  logic [AWID-1:0]  a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] mem [WORDS];

  // Active-low selects; per-bit write mask, registered read port.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!gwen) mem[a] <= (mem[a] & wen) | (d & ~wen);
      else       q      <= mem[a];
    end
  end
endmodule

module sram_banked_ctrl #(
  parameter int NUM_WORDS  = 256,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int INIT_ZERO  = 1,
  localparam int AW  = $clog2(NUM_WORDS),
  localparam int NBE = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [NBE-1:0]        be_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  init_done_o
);
  localparam int BANK_WORDS = NUM_WORDS / NUM_BANKS;
  localparam int BW  = $clog2(NUM_BANKS);
  localparam int RW  = AW - BW;
  localparam int BSW = (BW > 0) ? BW : 1;

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [RW-1:0]         row_cnt;
  logic                  rvalid_q;
  logic [BSW-1:0]        rbank_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [BSW-1:0]        bank_sel;
  logic [RW-1:0]         row_sel;
  logic                  ready;
  logic                  clearing;

  logic [NUM_BANKS-1:0]  bank_cen;
  logic [NUM_BANKS-1:0]  bank_gwen;
  logic [DATA_WIDTH-1:0] bank_wen [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_q   [NUM_BANKS];
  logic [RW-1:0]         mac_addr;
  logic [DATA_WIDTH-1:0] mac_d;

  assign row_sel = addr_i[RW-1:0];

  if (BW > 0) begin : g_bank_idx
    assign bank_sel = addr_i[AW-1:RW];
  end else begin : g_single_bank
    assign bank_sel = '0;
  end

  // rst gates everything combinationally so the reset cycle itself is quiet.
  assign ready       = (state == READY) && !rst;
  assign clearing    = (state == INIT) && !rst && (INIT_ZERO != 0);
  assign gnt_o       = ready && req_i;
  assign init_done_o = ready;
  assign rvalid_o    = rvalid_q && !rst;
  assign rdata_o     = rst ? '0 : (rvalid_q ? bank_q[rbank_q] : rdata_q);

  always_comb begin
    bank_cen  = '1;
    bank_gwen = '1;
    for (int i = 0; i < NUM_BANKS; i++) bank_wen[i] = '1;
    mac_addr  = row_sel;
    mac_d     = wdata_i;
    if (clearing) begin
      bank_cen  = '0;
      bank_gwen = '0;
      for (int i = 0; i < NUM_BANKS; i++) bank_wen[i] = '0;
      mac_addr  = row_cnt;
      mac_d     = '0;
    end else if (gnt_o) begin
      bank_cen[bank_sel] = 1'b0;
      if (we_i) begin
        bank_gwen[bank_sel] = 1'b0;
        for (int b = 0; b < NBE; b++) bank_wen[bank_sel][8*b +: 8] = {8{~be_i[b]}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      row_cnt  <= '0;
      rvalid_q <= 1'b0;
      rbank_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt_o && !we_i;
      if (gnt_o && !we_i) rbank_q <= bank_sel;
      // Capture the presented word so rdata_o holds between reads.
      if (rvalid_q) rdata_q <= bank_q[rbank_q];
      case (state)
        INIT: begin
          if (INIT_ZERO == 0) begin
            state <= READY;
          end else begin
            if (row_cnt == RW'(BANK_WORDS - 1)) state <= READY;
            row_cnt <= row_cnt + 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    gf180mcu_sram_wrapper #(
      .WORDS (BANK_WORDS),
      .WIDTH (DATA_WIDTH)
    ) u_sram (
      .clk  (clk),
      .cen  (bank_cen[g]),
      .gwen (bank_gwen[g]),
      .wen  (bank_wen[g]),
      .a    (mac_addr),
      .d    (mac_d),
      .q    (bank_q[g])
    );
  end
endmodule

// File: tb/tb_sram_banked_ctrl.sv
// tb/tb_sram_banked_ctrl.sv - scoreboard bench for sram_banked_ctrl
// Default instance is scoreboarded against a word-array model; a second instance covers INIT_ZERO=0.

module tb_sram_banked_ctrl;
  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt_o, rvalid_o, init_done_o;
  logic [31:0] rdata_o;

  logic        rst_nz, req_nz;
  logic        gnt_nz, rvalid_nz, done_nz;
  logic [31:0] rdata_nz;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [256];
  logic [31:0] exp_q [$];
  logic [31:0] exp_last = '0;

  always #5 clk = ~clk;

  sram_banked_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .init_done_o(init_done_o)
  );

  sram_banked_ctrl #(.INIT_ZERO(0)) dut_nz (
    .clk(clk), .rst(rst_nz), .req_i(req_nz), .we_i(1'b0), .addr_i(8'h03),
    .wdata_i(32'h0), .be_i(4'h0), .gnt_o(gnt_nz), .rvalid_o(rvalid_nz),
    .rdata_o(rdata_nz), .init_done_o(done_nz)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every read response is popped and compared; otherwise rdata must hold.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      exp_last = '0;
    end else if (rvalid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rvalid: got rdata %h expected no response", rdata_o);
      end else begin
        exp_last = exp_q.pop_front();
        chk("rdata", rdata_o, exp_last);
      end
    end else begin
      chk("rdata_hold", rdata_o, exp_last);
    end
  end

  task automatic access(input bit w, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] b);
    logic [3:0] exp_cen;
    req = 1'b1; we = w; addr = a; wdata = wd; be = b;
    @(negedge clk);
    chk("gnt", {31'b0, gnt_o}, 32'd1);
    exp_cen = 4'hF;
    exp_cen[a[7:6]] = 1'b0;
    chk("bank_cen", {28'b0, dut.bank_cen}, {28'b0, exp_cen});
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) model[a][8*i +: 8] = wd[8*i +: 8];
    end else begin
      exp_q.push_back(model[a]);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_init(input int exp_cycles);
    int n;
    n = 0;
    req = 1'b1; we = 1'b0; addr = 8'h55;
    while (n < 200) begin
      @(negedge clk);
      if (init_done_o === 1'b1) break;
      chk("init_gnt", {31'b0, gnt_o}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    chk("init_cycles", n, exp_cycles);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = '0;
    rst_nz = 1'b1; req_nz = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", {31'b0, gnt_o}, 32'd0);
      chk("rst_done", {31'b0, init_done_o}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init(64);

    access(0, 8'h00, 0, 0);
    access(0, 8'h7F, 0, 0);
    access(0, 8'hFF, 0, 0);

    access(1, 8'h0A, 32'hFFFFFFFF, 4'hF);
    access(1, 8'h0A, 32'hDEADBEEF, 4'hC);
    access(0, 8'h0A, 0, 0);

    access(1, 8'h3F, 32'h11111111, 4'hF);
    access(1, 8'h40, 32'h22222222, 4'hF);
    access(0, 8'h3F, 0, 0);
    access(0, 8'h40, 0, 0);

    access(1, 8'hFF, 32'hAAAAAAAA, 4'h0);
    access(0, 8'hFF, 0, 0);

    // Write then read the same address on the next cycle.
    access(1, 8'hC3, 32'h5A5A1234, 4'hF);
    access(0, 8'hC3, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end else begin
        access($urandom_range(0, 1) == 1, 8'($urandom_range(0, 15) * 17),
               $urandom, 4'($urandom_range(0, 15)));
      end
    end
    repeat (2) @(posedge clk);
    #1;

    // Read aborted by reset on the following cycle, then full re-clear.
    req = 1'b1; we = 1'b0; addr = 8'h0A;
    @(negedge clk);
    chk("abort_gnt", {31'b0, gnt_o}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("abort_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("abort_done", {31'b0, init_done_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;
    wait_init(64);
    access(0, 8'h0A, 0, 0);
    access(0, 8'h3F, 0, 0);
    access(0, 8'h40, 0, 0);

    // INIT_ZERO=0 instance.
    @(negedge clk);
    chk("nz_rst_done", {31'b0, done_nz}, 32'd0);
    @(posedge clk); #1;
    rst_nz = 1'b0; req_nz = 1'b1;
    @(negedge clk);
    chk("nz_init_done", {31'b0, done_nz}, 32'd0);
    chk("nz_init_gnt", {31'b0, gnt_nz}, 32'd0);
    @(posedge clk); #1;
    chk("nz_done_1cyc", {31'b0, done_nz}, 32'd1);
    @(negedge clk);
    chk("nz_gnt", {31'b0, gnt_nz}, 32'd1);
    @(posedge clk); #1;
    req_nz = 1'b0; rst_nz = 1'b1;
    @(negedge clk);
    chk("nz_abort_rvalid", {31'b0, rvalid_nz}, 32'd0);
    @(posedge clk); #1;
    rst_nz = 1'b0;
    @(negedge clk);
    chk("nz_rvalid_after", {31'b0, rvalid_nz}, 32'd0);
    chk("nz_redone_0", {31'b0, done_nz}, 32'd0);
    @(posedge clk); #1;
    chk("nz_redone_1", {31'b0, done_nz}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_reads", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
